qwi_regbank: RTL and testbench
==============================

Name: qwi_regbank

Overview:
- Parametrised successor to the register controller.
- Bridges the BRAM-style register port (ce / byte-we / word addr / wrd / rdd) from the processor to REGCNT flat register slices.
- Adds per-register access modes (RW, RO, W1C, PULSE), per-register reset values, configurable read latency with a read-valid strobe, per-register access strobes, and out-of-range error reporting.
- Sits between the AXI-BRAM controller and the video/format logic.

Parameters:
- REGCNT, 2, number of registers.
- AWID, 11, word-address width; valid addresses 0..REGCNT-1.
- DWID, 32, data width; a multiple of 8.
- RDLAT, 1, read latency in cycles; legal values 1 or 2.
- REG_MODE, all 0, REGCNT*2 bits; 2-bit mode per register, register i at [2i+1:2i].
- REG_RST, all 0, REGCNT*DWID bits; reset value per register, register i at [DWID*i +: DWID].

Ports:
- reg_clk  in  1  clock, all logic.
- reg_rst  in  1  synchronous active-high reset.
- reg_ce  in  1  access enable.
- reg_we  in  DWID/8  byte write enables.
- reg_addr  in  AWID  word address.
- reg_wrd  in  DWID  write data.
- reg_rdd  out  DWID  read data.
- reg_rdv  out  1  read data valid, one-cycle pulse.
- reg_err  out  1  out-of-range access, one-cycle pulse.
- reg_out  out  REGCNT*DWID  register values to fabric.
- reg_in  in  REGCNT*DWID  status/event inputs from fabric.
- reg_wr_stb  out  REGCNT  per-register write pulse.
- reg_rd_stb  out  REGCNT  per-register read pulse.

Behaviour:
- Clock and reset: one clock, reg_clk; reset is synchronous and active-high on reg_rst.
- Access decode:
  - Write = reg_ce & |reg_we.
  - Read = reg_ce & (reg_we == 0).
  - In range = reg_addr < REGCNT.
- Reset values:
  - Stored registers load REG_RST.
  - reg_rdd, reg_rdv, reg_err, reg_wr_stb, reg_rd_stb are 0.
  - Read pipeline is flushed.
  - reg_rst asserted mid-read means that read never produces reg_rdv.
- Byte enables: only bytes whose reg_we bit is 1 are affected; other bytes hold.
- Mode 0, RW:
  - Write updates the stored value the next cycle.
  - reg_out = stored value.
  - Read returns the stored value.
- Mode 1, RO:
  - Writes are ignored, but reg_wr_stb still pulses.
  - reg_out = REG_RST constant.
  - Read returns the reg_in slice, sampled in the read-accept cycle.
- Mode 2, W1C:
  - Stored bit is set when the corresponding reg_in bit is 1 (sticky).
  - Writing 1 in an enabled byte clears the bit; writing 0 has no effect.
  - Set and clear in the same cycle: set wins.
  - reg_out = stored value; read returns the stored value.
- Mode 3, PULSE:
  - A write loads the enabled bytes for exactly one cycle, then the stored value returns to 0 (non-enabled bytes read 0).
  - reg_out shows the pulse.
  - Read returns 0.
- Strobes:
  - reg_wr_stb[i] pulses the cycle after an in-range write to address i, aligned with the updated reg_out.
  - reg_rd_stb[i] pulses the cycle after an in-range read accept.
- Read pipeline:
  - reg_rdd/reg_rdv valid RDLAT cycles after the accept cycle.
  - Back-to-back reads every cycle are supported, with one rdv per read, in order.
  - reg_rdd holds its last value when reg_rdv = 0.
- Out of range:
  - Write is ignored and reg_err pulses the next cycle.
  - Read returns 0 with reg_rdv, and reg_err pulses aligned with that reg_rdv.
- Simultaneous write and read are impossible by decode, since reg_we selects one.
- reg_addr wider than needed: the full AWID bits are compared; no aliasing.

Decomposition:
- Package qwi_regbank_pkg:
  - Mode constants MODE_RW=2'd0, MODE_RO=2'd1, MODE_W1C=2'd2, MODE_PULSE=2'd3.
  - Function to extract a register's mode from REG_MODE.
- Sub-module qwi_regbank_cell: one register, parametrised by DWID, mode and reset value.
  - Inputs: write enable, byte enables, write data, reg_in slice.
  - Outputs: stored value and read value.
  - Generated REGCNT times.
- The top level holds the decode, the read mux/pipeline and the strobes.

Test Plan:
- Reset/RW: REGCNT=2, REG_RST={32'h0,32'h0105}. Release reset, read addr 0 -> reg_rdv after RDLAT with reg_rdd=32'h0105. Write addr 1 =3, we=4'hf -> reg_out[63:32]=3 and reg_wr_stb=2'b10 the next cycle.
- Byte enables: addr 1 holds 32'h11223344; write 32'hAABBCCDD, we=4'b0101 -> read returns 32'h11BB33DD.
- RO and W1C:
  - RO register with reg_in=32'hCAFE0001: write 32'hFFFFFFFF -> reg_out unchanged; read returns 32'hCAFE0001.
  - W1C register: pulse reg_in bit 4 -> read 32'h10.
  - Write 32'h10 in the same cycle reg_in bit 4 is high -> bit stays 1.
  - Write 32'h10 alone -> read 0.
- PULSE: write 32'h1 -> reg_out bit 0 is high for exactly one cycle; a following read returns 0.
- Pipeline/errors (RDLAT=2):
  - Reads on 4 consecutive cycles to addrs 0,1,5,0 -> 4 consecutive rdv with correct data; the third returns 0 with reg_err=1.
  - Write to addr 7 -> no reg_out change, reg_err pulse.
- Reset mid-read: assert reg_rst the cycle after a read accept -> no reg_rdv; all registers back to REG_RST.

Source files
------------

// File: rtl/qwi_regbank_pkg.sv
// ----------------------------------------------------------------------------
// qwi_regbank_pkg
// Shared definitions for the qwi_regbank register bank.
//   MODE_*       : 2-bit per-register access mode encodings
//   reg_mode_of  : pulls one register's mode out of a packed REG_MODE vector
// No ports (package).
// ----------------------------------------------------------------------------
package qwi_regbank_pkg;

    localparam logic [1:0] MODE_RW    = 2'd0;
    localparam logic [1:0] MODE_RO    = 2'd1;
    localparam logic [1:0] MODE_W1C   = 2'd2;
    localparam logic [1:0] MODE_PULSE = 2'd3;

    // Upper bound on bank size accepted by reg_mode_of; callers zero-extend
    // their REG_MODE vector to this width before the call.
    localparam int MAX_REGS = 1024;

    function automatic logic [1:0] reg_mode_of(input logic [2*MAX_REGS-1:0] modes,
                                               input int idx);
        return modes[2*idx +: 2];
    endfunction

endpackage

// File: rtl/qwi_regbank_cell.sv
// ----------------------------------------------------------------------------
// qwi_regbank_cell
// One register of the bank; behaviour fixed at elaboration by MODE.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (loads RST_VAL)
//   wr_en      : in-range write addressed to this register
//   wr_be      : byte enables for the write
//   wr_data    : write data
//   in_val     : fabric status/event input slice
//   value      : stored value driven to the fabric
//   rd_val     : value returned on a processor read
// ----------------------------------------------------------------------------
module qwi_regbank_cell
    import qwi_regbank_pkg::*;
#(
    parameter int              DWID    = 32,
    parameter logic [1:0]      MODE    = MODE_RW,
    parameter logic [DWID-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DWID/8-1:0] wr_be,
    input  logic [DWID-1:0]   wr_data,
    input  logic [DWID-1:0]   in_val,
    output logic [DWID-1:0]   value,
    output logic [DWID-1:0]   rd_val
);

    logic [DWID-1:0] value_d, value_q;
    logic [DWID-1:0] byte_mask;
    logic [DWID-1:0] wr_bits;

    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < DWID/8; b++) begin
            byte_mask[8*b +: 8] = {8{wr_be[b]}};
        end
        wr_bits = wr_en ? (wr_data & byte_mask) : '0;
        value_d = value_q;
        case (MODE)
            MODE_RW:    if (wr_en) value_d = (value_q & ~byte_mask) | wr_bits;
            MODE_RO:    value_d = value_q;
            // Event input is OR-ed in after the clear so a coincident set wins.
            MODE_W1C:   value_d = (value_q & ~wr_bits) | in_val;
            MODE_PULSE: value_d = wr_bits;
            default:    value_d = value_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) value_q <= RST_VAL;
        else     value_q <= value_d;
    end

    assign value  = value_q;
    // RO reads the live fabric input; PULSE always reads back as zero.
    assign rd_val = (MODE == MODE_RO)    ? in_val :
                    (MODE == MODE_PULSE) ? '0     : value_q;

endmodule

// File: rtl/qwi_regbank.sv
// ----------------------------------------------------------------------------
// qwi_regbank
// BRAM-style processor register port to REGCNT flat register slices.
// Ports:
//   reg_clk, reg_rst : clock, synchronous active-high reset
//   reg_ce, reg_we   : access enable, byte write enables (we==0 means read)
//   reg_addr         : word address, valid 0..REGCNT-1
//   reg_wrd, reg_rdd : write data, read data (holds between reads)
//   reg_rdv          : read data valid, RDLAT cycles after accept
//   reg_err          : out-of-range access pulse
//   reg_out, reg_in  : register values to fabric, status/events from fabric
//   reg_wr_stb       : per-register write pulse
//   reg_rd_stb       : per-register read pulse
// ----------------------------------------------------------------------------
module qwi_regbank
    import qwi_regbank_pkg::*;
#(
    parameter int                      REGCNT   = 2,
    parameter int                      AWID     = 11,
    parameter int                      DWID     = 32,
    parameter int                      RDLAT    = 1,
    parameter logic [REGCNT*2-1:0]     REG_MODE = '0,
    parameter logic [REGCNT*DWID-1:0]  REG_RST  = '0
) (
    input  logic                   reg_clk,
    input  logic                   reg_rst,
    input  logic                   reg_ce,
    input  logic [DWID/8-1:0]      reg_we,
    input  logic [AWID-1:0]        reg_addr,
    input  logic [DWID-1:0]        reg_wrd,
    output logic [DWID-1:0]        reg_rdd,
    output logic                   reg_rdv,
    output logic                   reg_err,
    output logic [REGCNT*DWID-1:0] reg_out,
    input  logic [REGCNT*DWID-1:0] reg_in,
    output logic [REGCNT-1:0]      reg_wr_stb,
    output logic [REGCNT-1:0]      reg_rd_stb
);

    localparam logic [AWID:0] REGCNT_W = (AWID+1)'(REGCNT);

    logic              wr_acc, rd_acc, in_range;
    logic [REGCNT-1:0] wr_sel, rd_sel;
    logic [DWID-1:0]   cell_rd [REGCNT];
    logic [DWID-1:0]   rd_mux;

    assign wr_acc   = reg_ce & (|reg_we);
    assign rd_acc   = reg_ce & ~(|reg_we);
    // Full-width compare so high address bits never alias onto a register.
    assign in_range = {1'b0, reg_addr} < REGCNT_W;

    for (genvar i = 0; i < REGCNT; i++) begin : g_cell
        assign wr_sel[i] = wr_acc & (reg_addr == AWID'(i));
        assign rd_sel[i] = rd_acc & (reg_addr == AWID'(i));

        qwi_regbank_cell #(
            .DWID    (DWID),
            .MODE    (reg_mode_of((2*MAX_REGS)'(REG_MODE), i)),
            .RST_VAL (REG_RST[DWID*i +: DWID])
        ) u_cell (
            .clk     (reg_clk),
            .rst     (reg_rst),
            .wr_en   (wr_sel[i]),
            .wr_be   (reg_we),
            .wr_data (reg_wrd),
            .in_val  (reg_in[DWID*i +: DWID]),
            .value   (reg_out[DWID*i +: DWID]),
            .rd_val  (cell_rd[i])
        );
    end

    // Out-of-range addresses match no register, so the mux yields zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < REGCNT; i++) begin
            if (reg_addr == AWID'(i)) rd_mux = cell_rd[i];
        end
    end

    logic            pipe_vld_d [RDLAT];
    logic            pipe_vld_q [RDLAT];
    logic            pipe_err_d [RDLAT];
    logic            pipe_err_q [RDLAT];
    logic [DWID-1:0] pipe_dat_d [RDLAT];
    logic [DWID-1:0] pipe_dat_q [RDLAT];
    logic              wr_err_d, wr_err_q;
    logic [REGCNT-1:0] wr_stb_d, wr_stb_q, rd_stb_d, rd_stb_q;

    // Read pipeline: data stages only load on a valid entry, so the last
    // stage (reg_rdd) holds its value between reads.
    always_comb begin
        pipe_vld_d[0] = rd_acc;
        pipe_err_d[0] = rd_acc & ~in_range;
        pipe_dat_d[0] = rd_acc ? rd_mux : pipe_dat_q[0];
        for (int k = 1; k < RDLAT; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1];
            pipe_err_d[k] = pipe_err_q[k-1];
            pipe_dat_d[k] = pipe_vld_q[k-1] ? pipe_dat_q[k-1] : pipe_dat_q[k];
        end
        wr_err_d = wr_acc & ~in_range;
        wr_stb_d = wr_sel;
        rd_stb_d = rd_sel;
    end

    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            for (int k = 0; k < RDLAT; k++) begin
                pipe_vld_q[k] <= 1'b0;
                pipe_err_q[k] <= 1'b0;
                pipe_dat_q[k] <= '0;
            end
            wr_err_q <= 1'b0;
            wr_stb_q <= '0;
            rd_stb_q <= '0;
        end else begin
            for (int k = 0; k < RDLAT; k++) begin
                pipe_vld_q[k] <= pipe_vld_d[k];
                pipe_err_q[k] <= pipe_err_d[k];
                pipe_dat_q[k] <= pipe_dat_d[k];
            end
            wr_err_q <= wr_err_d;
            wr_stb_q <= wr_stb_d;
            rd_stb_q <= rd_stb_d;
        end
    end

    assign reg_rdv    = pipe_vld_q[RDLAT-1];
    assign reg_rdd    = pipe_dat_q[RDLAT-1];
    assign reg_err    = wr_err_q | pipe_err_q[RDLAT-1];
    assign reg_wr_stb = wr_stb_q;
    assign reg_rd_stb = rd_stb_q;

endmodule

// File: tb/tb_qwi_regbank.sv
// ----------------------------------------------------------------------------
// tb_qwi_regbank
// Bank of five registers: 0 RW (reset 0x0105), 1 RW, 2 RO (reset 0x5A5A0000),
// 3 W1C, 4 PULSE; two-cycle read latency. Read expectations go into a
// scoreboard queue together with the cycle they are due; a negedge monitor
// pops one entry per reg_rdv. Register outputs, strobes and errors are
// compared directly after each access.
// ----------------------------------------------------------------------------
module tb_qwi_regbank;

    localparam int REGCNT = 5;
    localparam int AWID   = 11;
    localparam int DWID   = 32;
    localparam int RDLAT  = 2;
    localparam logic [REGCNT*2-1:0]    MODES = {2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
    localparam logic [REGCNT*DWID-1:0] RSTS  = {32'h0, 32'h0, 32'h5A5A0000,
                                                32'h0, 32'h00000105};

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   reg_rst = 1'b1;
    logic                   reg_ce = 1'b0;
    logic [DWID/8-1:0]      reg_we = '0;
    logic [AWID-1:0]        reg_addr = '0;
    logic [DWID-1:0]        reg_wrd = '0;
    logic [DWID-1:0]        reg_rdd;
    logic                   reg_rdv;
    logic                   reg_err;
    logic [REGCNT*DWID-1:0] reg_out;
    logic [REGCNT*DWID-1:0] reg_in = '0;
    logic [REGCNT-1:0]      reg_wr_stb;
    logic [REGCNT-1:0]      reg_rd_stb;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    qwi_regbank #(
        .REGCNT(REGCNT), .AWID(AWID), .DWID(DWID), .RDLAT(RDLAT),
        .REG_MODE(MODES), .REG_RST(RSTS)
    ) dut (
        .reg_clk(clk), .reg_rst(reg_rst), .reg_ce(reg_ce), .reg_we(reg_we),
        .reg_addr(reg_addr), .reg_wrd(reg_wrd), .reg_rdd(reg_rdd),
        .reg_rdv(reg_rdv), .reg_err(reg_err), .reg_out(reg_out),
        .reg_in(reg_in), .reg_wr_stb(reg_wr_stb), .reg_rd_stb(reg_rd_stb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one access at a negedge; the following posedge accepts it.
    task automatic applyStimulus(input logic ce, input logic [3:0] we,
                                 input logic [AWID-1:0] addr,
                                 input logic [31:0] wrd);
        @(negedge clk);
        reg_ce   = ce;
        reg_we   = we;
        reg_addr = addr;
        reg_wrd  = wrd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'h0, '0, 32'h0);
    endtask

    task automatic doRead(input logic [AWID-1:0] addr, input logic [31:0] data,
                          input logic err);
        exp_t e;
        applyStimulus(1'b1, 4'h0, addr, 32'h0);
        e.data = data;
        e.err  = err;
        e.due  = cyc + RDLAT;
        sb.push_back(e);
    endtask

    // Read monitor: every reg_rdv must match the oldest outstanding read,
    // both in content and in the cycle it arrives.
    always @(negedge clk) begin
        exp_t e;
        if (reg_rdv) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rdv_unexpected: got rdv=1 rdd=%h expected no read", reg_rdd);
            end else begin
                e = sb.pop_front();
                checkOutput("rd_data", reg_rdd, e.data);
                checkOutput("rd_err", 32'(reg_err), 32'(e.err));
                checkOutput("rd_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        // Reset state.
        repeat (3) idle();
        checkOutput("rst_rdv", 32'(reg_rdv), 32'h0);
        checkOutput("rst_err", 32'(reg_err), 32'h0);
        checkOutput("rst_rdd", reg_rdd, 32'h0);
        checkOutput("rst_wr_stb", 32'(reg_wr_stb), 32'h0);
        checkOutput("rst_r0", reg_out[31:0], 32'h00000105);
        checkOutput("rst_r2", reg_out[95:64], 32'h5A5A0000);
        reg_rst = 1'b0;

        // RW read of reset value, then full-word write.
        doRead(11'd0, 32'h00000105, 1'b0);
        idle();
        checkOutput("rd_stb_r0", 32'(reg_rd_stb), 32'h01);
        repeat (3) idle();
        applyStimulus(1'b1, 4'hF, 11'd1, 32'h3);
        idle();
        checkOutput("rw_r1_out", reg_out[63:32], 32'h3);
        checkOutput("wr_stb_r1", 32'(reg_wr_stb), 32'h02);
        idle();
        checkOutput("wr_stb_clr", 32'(reg_wr_stb), 32'h0);

        // Byte enables.
        applyStimulus(1'b1, 4'hF, 11'd1, 32'h11223344);
        applyStimulus(1'b1, 4'b0101, 11'd1, 32'hAABBCCDD);
        idle();
        checkOutput("be_r1_out", reg_out[63:32], 32'h11BB33DD);
        doRead(11'd1, 32'h11BB33DD, 1'b0);
        repeat (3) idle();

        // RO: writes ignored but strobed; reads return the fabric input.
        reg_in[95:64] = 32'hCAFE0001;
        applyStimulus(1'b1, 4'hF, 11'd2, 32'hFFFFFFFF);
        idle();
        checkOutput("ro_r2_out", reg_out[95:64], 32'h5A5A0000);
        checkOutput("wr_stb_r2", 32'(reg_wr_stb), 32'h04);
        doRead(11'd2, 32'hCAFE0001, 1'b0);
        repeat (3) idle();

        // W1C: sticky set, set beats clear, write-one clears.
        reg_in[100] = 1'b1;
        idle();
        reg_in[100] = 1'b0;
        idle();
        checkOutput("w1c_set_out", reg_out[127:96], 32'h10);
        doRead(11'd3, 32'h10, 1'b0);
        applyStimulus(1'b1, 4'hF, 11'd3, 32'h10);
        reg_in[100] = 1'b1;
        idle();
        reg_in[100] = 1'b0;
        doRead(11'd3, 32'h10, 1'b0);
        applyStimulus(1'b1, 4'hF, 11'd3, 32'h10);
        doRead(11'd3, 32'h0, 1'b0);
        repeat (3) idle();

        // PULSE: one-cycle value, non-enabled bytes zero, reads zero.
        applyStimulus(1'b1, 4'hF, 11'd4, 32'h1);
        idle();
        checkOutput("pulse_hi", reg_out[159:128], 32'h1);
        idle();
        checkOutput("pulse_lo", reg_out[159:128], 32'h0);
        applyStimulus(1'b1, 4'b0001, 11'd4, 32'hFFFFFFFF);
        idle();
        checkOutput("pulse_be", reg_out[159:128], 32'h000000FF);
        doRead(11'd4, 32'h0, 1'b0);
        repeat (3) idle();

        // Back-to-back reads including one out of range.
        doRead(11'd0, 32'h00000105, 1'b0);
        doRead(11'd1, 32'h11BB33DD, 1'b0);
        doRead(11'd5, 32'h0, 1'b1);
        doRead(11'd0, 32'h00000105, 1'b0);
        repeat (4) idle();

        // Out-of-range write.
        applyStimulus(1'b1, 4'hF, 11'd7, 32'hFFFFFFFF);
        idle();
        checkOutput("oor_err", 32'(reg_err), 32'h1);
        checkOutput("oor_wr_stb", 32'(reg_wr_stb), 32'h0);
        checkOutput("oor_r0", reg_out[31:0], 32'h00000105);
        checkOutput("oor_r1", reg_out[63:32], 32'h11BB33DD);
        idle();
        checkOutput("oor_err_clr", 32'(reg_err), 32'h0);

        // Reset the cycle after a read accept: that read must never appear.
        applyStimulus(1'b1, 4'hF, 11'd0, 32'h0000DEAD);
        applyStimulus(1'b1, 4'h0, 11'd0, 32'h0);
        idle();
        reg_rst = 1'b1;
        repeat (2) idle();
        reg_rst = 1'b0;
        checkOutput("mid_rst_r0", reg_out[31:0], 32'h00000105);
        checkOutput("mid_rst_r1", reg_out[63:32], 32'h0);
        checkOutput("mid_rst_r2", reg_out[95:64], 32'h5A5A0000);
        checkOutput("mid_rst_r3", reg_out[127:96], 32'h0);
        checkOutput("mid_rst_rdd", reg_rdd, 32'h0);
        repeat (4) idle();

        checkOutput("sb_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
